// File: rtl/datapath_seq.sv
// Sequenced register-file/ALU datapath: one instruction per start handshake
// (IDLE -> READ -> EXEC -> WB), plus a direct load path into the register file.
module datapath_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] dados,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [AW-1:0]    addr_d,
  input  logic [2:0]       operacao,
  input  logic             Cin,
  input  logic             escrita,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             Cout,
  output logic             zero
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, b_q, d_q;
  logic [2:0]       op_q;
  logic             cin_q, esc_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] reg_a_q, reg_b_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q, zero_q, done_q;
  logic [WIDTH:0]   alu;
  logic             accept, do_load, wb_en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRead;
      StRead: state_d = StExec;
      StExec: state_d = StWb;
      StWb:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode; start wins over load in IDLE
  always_comb begin
    busy    = (state_q != StIdle);
    accept  = (state_q == StIdle) && start;
    do_load = (state_q == StIdle) && load && !start;
    wb_en   = (state_q == StWb) && esc_q;
  end

  // ALU at WIDTH+1 bits; the top bit is the carry/shift-out
  always_comb begin
    alu = '0;
    unique case (op_q)
      3'b000: alu = {1'b0, reg_a_q} + {1'b0, reg_b_q} + (WIDTH+1)'(cin_q);
      3'b001: alu = {1'b0, reg_a_q} + {1'b0, ~reg_b_q} + (WIDTH+1)'(1);
      3'b010: alu = {1'b0, reg_a_q & reg_b_q};
      3'b011: alu = {1'b0, reg_a_q | reg_b_q};
      3'b100: alu = {1'b0, reg_a_q ^ reg_b_q};
      3'b101: alu = {1'b0, ~reg_a_q};
      3'b110: alu = {reg_a_q[0], cin_q, reg_a_q[WIDTH-1:1]};
      3'b111: alu = {reg_a_q, cin_q};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      esc_q   <= 1'b0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      done_q <= (state_q == StWb);
      if (accept) begin
        a_q   <= addr_a;
        b_q   <= addr_b;
        d_q   <= addr_d;
        op_q  <= operacao;
        cin_q <= Cin;
        esc_q <= escrita;
      end
      if (state_q == StRead) begin
        reg_a_q <= rf_q[a_q];
        reg_b_q <= rf_q[b_q];
      end
      if (state_q == StExec) begin
        res_q  <= alu[WIDTH-1:0];
        cout_q <= alu[WIDTH];
        zero_q <= (alu[WIDTH-1:0] == '0);
      end
      if (do_load)    rf_q[addr_d] <= dados;
      else if (wb_en) rf_q[d_q]    <= res_q;
    end
  end

  assign done      = done_q;
  assign resultado = res_q;
  assign Cout      = cout_q;
  assign zero      = zero_q;

endmodule
